// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset/bubble constants and the
// redirect-cause encoding shared with EX and the BTB.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    RedirNone = 2'd0,
    RedirBr   = 2'd1,
    RedirJalr = 2'd2
  } redirect_cause_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInst        = 32'h0000_0013;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

  // Instruction addresses must be word aligned; anything else stops fetch.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch-stage performance counters (only instantiated when FETCH_PERF_EN is defined).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   fetch_inc             IF/ID loaded a valid instruction this cycle
//   flush_inc             a flush or JALR redirect was accepted this cycle
//   stall_inc             fetch FSM sat in its stall state this cycle
//   fetch_cnt/flush_cnt/stall_cnt   32-bit wrapping counts
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc,
  input  logic        flush_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] stall_cnt
);

  logic [31:0] fetch_q, flush_q, stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_q <= 32'd0;
      flush_q <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      if (fetch_inc) fetch_q <= fetch_q + 32'd1;
      if (flush_inc) flush_q <= flush_q + 32'd1;
      if (stall_inc) stall_q <= stall_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign flush_cnt = flush_q;
  assign stall_cnt = stall_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues the I-cache read, and drives the IF/ID register.
// Takes next-PC/taken/flush from the branch predictor and JALR redirects from EX.
// Optional counters are built when FETCH_PERF_EN is defined; otherwise perf ports read 0.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   mem_stall_i                     memory busy: whole stage frozen
//   hazard_stall_i                  load-use stall: hold PC and IF/ID
//   ic_ren_o, ic_addr_o, ic_rdata_i I-cache request / address / returned instruction
//   btb_pc_o                        current PC to the predictor
//   btb_next_pc_i, btb_taken_i      predicted next PC and direction
//   btb_flush_i                     mispredict; btb_next_pc_i is the corrected PC
//   jalr_redirect_i, jalr_target_i  resolved JALR from EX
//   id_valid_o, id_pc_o, id_inst_o, id_pred_taken_o   IF/ID register
//   halt_o                          fetch stopped on a misaligned redirect target
//   perf_fetch_o, perf_flush_o, perf_stall_o          performance counters
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault,
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_stall_i,
  input  logic        hazard_stall_i,
  output logic        ic_ren_o,
  output logic [31:0] ic_addr_o,
  input  logic [31:0] ic_rdata_i,
  output logic [31:0] btb_pc_o,
  input  logic [31:0] btb_next_pc_i,
  input  logic        btb_taken_i,
  input  logic        btb_flush_i,
  input  logic        jalr_redirect_i,
  input  logic [31:0] jalr_target_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_pred_taken_o,
  output logic        halt_o,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_flush_o,
  output logic [31:0] perf_stall_o
);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [31:0]     id_pc_q, id_pc_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic            id_pred_q, id_pred_d;
  redirect_cause_e cause;
  logic [31:0]     redir_target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'd0;
      id_inst_q  <= NOP_INST;
      id_pred_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_pred_q  <= id_pred_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;
    id_pred_d    = id_pred_q;
    cause        = RedirNone;
    redir_target = pc_q;

    // Flush outranks JALR; both at once is a protocol error caught below.
    if (btb_flush_i) begin
      cause        = RedirBr;
      redir_target = btb_next_pc_i;
    end else if (jalr_redirect_i) begin
      cause        = RedirJalr;
      redir_target = jalr_target_i;
    end

    case (state_q)
      StBoot: state_d = StRun;
      // The cycle mem_stall_i drops out of StStall is an ordinary run cycle.
      StRun, StStall: begin
        if (mem_stall_i) begin
          state_d = StStall;
        end else begin
          state_d = StRun;
          if (cause != RedirNone) begin
            // Redirect squashes IF/ID even under hazard_stall_i: that instruction is younger.
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            id_pred_d  = 1'b0;
            if (is_misaligned(redir_target)) begin
              state_d = StHalt;
            end else begin
              pc_d = redir_target;
            end
          end else if (!hazard_stall_i) begin
            pc_d       = btb_next_pc_i;
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_inst_d  = ic_rdata_i;
            id_pred_d  = btb_taken_i;
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  assign ic_ren_o        = (state_q == StRun) || (state_q == StStall);
  assign ic_addr_o       = pc_q;
  assign btb_pc_o        = pc_q;
  assign halt_o          = (state_q == StHalt);
  assign id_valid_o      = id_valid_q && (state_q != StHalt);
  assign id_pc_o         = id_pc_q;
  assign id_inst_o       = id_inst_q;
  assign id_pred_taken_o = id_pred_q;

`ifdef FETCH_PERF_EN
  logic run_cycle;
  logic fetch_inc, flush_inc, stall_inc;

  assign run_cycle = ((state_q == StRun) || (state_q == StStall)) && !mem_stall_i;
  assign fetch_inc = run_cycle && !btb_flush_i && !jalr_redirect_i && !hazard_stall_i;
  assign flush_inc = run_cycle && (btb_flush_i || jalr_redirect_i);
  assign stall_inc = (state_q == StStall);

  fetch_perf_ctr u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_inc (fetch_inc),
    .flush_inc (flush_inc),
    .stall_inc (stall_inc),
    .fetch_cnt (perf_fetch_o),
    .flush_cnt (perf_flush_o),
    .stall_cnt (perf_stall_o)
  );
`else
  assign perf_fetch_o = 32'd0;
  assign perf_flush_o = 32'd0;
  assign perf_stall_o = 32'd0;
`endif

`ifndef SYNTHESIS
  redirect_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(btb_flush_i && jalr_redirect_i));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        mem_stall_i = 1'b0, hazard_stall_i = 1'b0;
  logic        btb_taken_i = 1'b0, btb_flush_i = 1'b0, jalr_redirect_i = 1'b0;
  logic [31:0] ic_rdata_i = 32'd0, btb_next_pc_i = 32'd0, jalr_target_i = 32'd0;
  logic        ic_ren_o, id_valid_o, id_pred_taken_o, halt_o;
  logic [31:0] ic_addr_o, btb_pc_o, id_pc_o, id_inst_o;
  logic [31:0] perf_fetch_o, perf_flush_o, perf_stall_o;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_stall_i     (mem_stall_i),
    .hazard_stall_i  (hazard_stall_i),
    .ic_ren_o        (ic_ren_o),
    .ic_addr_o       (ic_addr_o),
    .ic_rdata_i      (ic_rdata_i),
    .btb_pc_o        (btb_pc_o),
    .btb_next_pc_i   (btb_next_pc_i),
    .btb_taken_i     (btb_taken_i),
    .btb_flush_i     (btb_flush_i),
    .jalr_redirect_i (jalr_redirect_i),
    .jalr_target_i   (jalr_target_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_pred_taken_o (id_pred_taken_o),
    .halt_o          (halt_o),
    .perf_fetch_o    (perf_fetch_o),
    .perf_flush_o    (perf_flush_o),
    .perf_stall_o    (perf_stall_o)
  );

  typedef struct {
    logic        ic_ren;
    logic [31:0] ic_addr;
    logic        halt;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred;
    logic [31:0] pf, pfl, pst;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: abstract fetch behaviour as flags and plain arithmetic.
  logic [31:0] m_pc = 0, m_id_pc = 0, m_id_inst = 32'h13;
  logic [31:0] m_fetch = 0, m_flush = 0, m_stall = 0;
  bit m_boot = 1, m_halt = 0, m_stalled = 0, m_id_valid = 0, m_id_pred = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected snapshot per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ic_ren", {31'd0, ic_ren_o}, {31'd0, e.ic_ren});
        chk("ic_addr", ic_addr_o, e.ic_addr);
        chk("btb_pc", btb_pc_o, e.ic_addr);
        chk("halt", {31'd0, halt_o}, {31'd0, e.halt});
        chk("id_valid", {31'd0, id_valid_o}, {31'd0, e.id_valid});
        chk("id_pc", id_pc_o, e.id_pc);
        chk("id_inst", id_inst_o, e.id_inst);
        chk("id_pred", {31'd0, id_pred_taken_o}, {31'd0, e.id_pred});
        chk("perf_fetch", perf_fetch_o, e.pf);
        chk("perf_flush", perf_flush_o, e.pfl);
        chk("perf_stall", perf_stall_o, e.pst);
      end
    end
  end

  // Drive one cycle's inputs, advance the model across the coming edge, queue the result.
  task automatic step(input bit r, input bit ms, input bit hz, input bit fl, input bit jr,
                      input logic [31:0] jt, input logic [31:0] np, input bit tk,
                      input logic [31:0] rd);
    logic [31:0] tgt;
    exp_t e;
    @(negedge clk);
    rst_n = r; mem_stall_i = ms; hazard_stall_i = hz; btb_flush_i = fl;
    jalr_redirect_i = jr; jalr_target_i = jt; btb_next_pc_i = np; btb_taken_i = tk;
    ic_rdata_i = rd;
    if (!r) begin
      m_pc = 32'd0; m_boot = 1; m_halt = 0; m_stalled = 0;
      m_id_valid = 0; m_id_pc = 0; m_id_inst = 32'h13; m_id_pred = 0;
      m_fetch = 0; m_flush = 0; m_stall = 0;
    end else if (m_halt) begin
      // only reset leaves halt
    end else if (m_boot) begin
      m_boot = 0;
    end else begin
      if (m_stalled) m_stall++;
      if (ms) begin
        m_stalled = 1;
      end else begin
        m_stalled = 0;
        if (fl || jr) begin
          tgt = fl ? np : jt;
          m_flush++;
          m_id_valid = 0; m_id_inst = 32'h13; m_id_pred = 0;
          if (tgt % 4 != 0) m_halt = 1;
          else m_pc = tgt;
        end else if (!hz) begin
          m_id_valid = 1; m_id_pc = m_pc; m_id_inst = rd; m_id_pred = tk;
          m_fetch++;
          m_pc = np;
        end
      end
    end
    e.ic_ren = !m_boot && !m_halt;
    e.ic_addr = m_pc;
    e.halt = m_halt;
    e.id_valid = m_id_valid && !m_halt;
    e.id_pc = m_id_pc;
    e.id_inst = m_id_inst;
    e.id_pred = m_id_pred;
`ifdef FETCH_PERF_EN
    e.pf = m_fetch; e.pfl = m_flush; e.pst = m_stall;
`else
    e.pf = 0; e.pfl = 0; e.pst = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, m_pc + 4, 1'($urandom), $urandom);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] r32, tgt, np;
    bit ms, hz, fl, jr, rs;
    int sel;

    // Reset, boot cycle, sequential fetch from 0 up to pc 0x10.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 32'd4, 0, 32'h1111_0000);  // boot: PC held
    plain(4);
    // Memory stall at 0x10 for three cycles, then release.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 32'h99, 1, $urandom);
    plain(1);
    // Flush beats hazard stall.
    step(1, 0, 1, 1, 0, 0, 32'h40, 1, $urandom);
    plain(2);
    // Misaligned JALR target halts; held until reset.
    step(1, 0, 0, 0, 1, 32'h42, m_pc + 4, 0, $urandom);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, m_pc + 4, 1, $urandom);

    // Counter scenario: 10 fetches, 2 flushes, 3 stall cycles.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 32'd4, 0, 0);
    plain(10);
    step(1, 0, 0, 1, 0, 0, m_pc + 8, 0, $urandom);
    step(1, 0, 0, 0, 1, m_pc + 16, m_pc + 4, 0, $urandom);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, m_pc + 4, 0, $urandom);
    step(1, 0, 1, 0, 0, 0, m_pc + 4, 0, $urandom);
    step(1, 0, 1, 0, 0, 0, m_pc + 4, 0, $urandom);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      rs = ($urandom % 200 == 0) || (m_halt && ($urandom % 4 == 0));
      ms = ($urandom % 5 == 0);
      hz = ($urandom % 5 == 0);
      sel = $urandom % 16;
      fl = (sel == 0);
      jr = (sel == 1);
      r32 = $urandom;
      tgt = {r32[31:2], 2'b00};
      if ($urandom % 8 == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      r32 = $urandom;
      np = ($urandom % 4 == 0) ? {r32[31:2], 2'b00} : m_pc + 4;
      if (fl) np = tgt;
      step(!rs, ms, hz, fl, jr, tgt, np, 1'($urandom), $urandom);
    end

    step(1, 0, 0, 0, 0, 0, m_pc + 4, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
